// File: rtl/comparator_serial_unsigned.sv
`timescale 1ns/1ps
// comparator_serial_unsigned
// Multi-cycle magnitude comparator. It applies the 1-bit greater/equal/lesser
// recurrence to a WIDTH-bit operand pair, BITS_PER_CYCLE bits per clock,
// starting with the least significant chunk. The running flags are registered
// between cycles. With signed_i set, the result follows two's-complement order.
//
// Ports:
//   clk_i        clock; all state changes on the rising edge
//   rst_n_i      asynchronous active-low reset
//   clear_i      synchronous abort back to IDLE; overrides every other transition
//   in_valid_i   operand pair offered
//   in_ready_o   block accepts operands (IDLE only)
//   a_i, b_i     operands, captured on the accept edge
//   signed_i     1 = two's-complement compare, captured on the accept edge
//   out_valid_o  result available (DONE)
//   out_ready_i  consumer takes the result
//   greater_o    A > B   (0 unless out_valid_o)
//   equal_o      A == B  (0 unless out_valid_o)
//   lesser_o     A < B   (0 unless out_valid_o)
//   busy_o       RUN or DONE
module comparator_serial_unsigned #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             greater_o,
  output logic             equal_o,
  output logic             lesser_o,
  output logic             busy_o
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N - 1);
  localparam logic [BITS_PER_CYCLE-1:0] MSB_MASK =
    BITS_PER_CYCLE'(1) << (BITS_PER_CYCLE - 1);

  generate
    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
      $error("comparator_serial_unsigned: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             signed_reg, signed_next;
  logic             gt_reg, gt_next;
  logic             eq_reg, eq_next;
  logic             lt_reg, lt_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // The operand registers shift right by one chunk per RUN cycle, so the
  // chunk being resolved always sits in the low BITS_PER_CYCLE bits.
  logic                      last_chunk;
  logic                      flip_sign;
  logic [BITS_PER_CYCLE-1:0] a_chunk;
  logic [BITS_PER_CYCLE-1:0] b_chunk;

  assign last_chunk = (cnt_reg == LAST_CHUNK);
  // Inverting both sign bits maps two's-complement order onto unsigned order.
  assign flip_sign  = signed_reg & last_chunk;
  assign a_chunk    = a_reg[BITS_PER_CYCLE-1:0] ^ (flip_sign ? MSB_MASK : '0);
  assign b_chunk    = b_reg[BITS_PER_CYCLE-1:0] ^ (flip_sign ? MSB_MASK : '0);

  // Chain of 1-bit cells. Index 0 carries the registered flags in; each cell
  // lets a differing bit override whatever the lower bits decided.
  logic [BITS_PER_CYCLE:0] gt_c;
  logic [BITS_PER_CYCLE:0] eq_c;
  logic [BITS_PER_CYCLE:0] lt_c;

  assign gt_c[0] = gt_reg;
  assign eq_c[0] = eq_reg;
  assign lt_c[0] = lt_reg;

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_cell
      logic bit_same;
      assign bit_same    = ~(a_chunk[gi] ^ b_chunk[gi]);
      assign gt_c[gi+1]  = (a_chunk[gi] & ~b_chunk[gi]) | (bit_same & gt_c[gi]);
      assign lt_c[gi+1]  = (~a_chunk[gi] & b_chunk[gi]) | (bit_same & lt_c[gi]);
      assign eq_c[gi+1]  = bit_same & eq_c[gi];
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    signed_next = signed_reg;
    gt_next     = gt_reg;
    eq_next     = eq_reg;
    lt_next     = lt_reg;
    cnt_next    = cnt_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (in_valid_i) begin
          a_next      = a_i;
          b_next      = b_i;
          signed_next = signed_i;
          gt_next     = 1'b0;
          eq_next     = 1'b1;
          lt_next     = 1'b0;
          cnt_next    = '0;
          state_next  = ST_RUN;
        end
      end
      ST_RUN: begin
        gt_next  = gt_c[BITS_PER_CYCLE];
        eq_next  = eq_c[BITS_PER_CYCLE];
        lt_next  = lt_c[BITS_PER_CYCLE];
        a_next   = a_reg >> BITS_PER_CYCLE;
        b_next   = b_reg >> BITS_PER_CYCLE;
        cnt_next = cnt_reg + CNT_W'(1);
        if (last_chunk) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Abort wins over accept, progress and handshake alike.
    if (clear_i) begin
      state_next = ST_IDLE;
      gt_next    = 1'b0;
      eq_next    = 1'b1;
      lt_next    = 1'b0;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg  <= ST_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      signed_reg <= 1'b0;
      gt_reg     <= 1'b0;
      eq_reg     <= 1'b1;
      lt_reg     <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      signed_reg <= signed_next;
      gt_reg     <= gt_next;
      eq_reg     <= eq_next;
      lt_reg     <= lt_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Handshake and result outputs depend on registered state only.
  assign in_ready_o  = (state_reg == ST_IDLE);
  assign out_valid_o = (state_reg == ST_DONE);
  assign busy_o      = (state_reg != ST_IDLE);
  assign greater_o   = out_valid_o & gt_reg;
  assign equal_o     = out_valid_o & eq_reg;
  assign lesser_o    = out_valid_o & lt_reg;

endmodule

// File: tb/tb_comparator_serial_unsigned.sv
`timescale 1ns/1ps
// Bench for comparator_serial_unsigned: three instances (1, 4 and 32 bits per
// cycle) share clock and reset. A transaction-level model predicts the
// handshake state and result of each instance and is compared every cycle;
// directed cases with literal expected results pin that model.
module tb_comparator_serial_unsigned;

  logic        clk;
  logic        rst_n;
  logic        clear_s     [3];
  logic        in_valid_s  [3];
  logic        in_ready_s  [3];
  logic [31:0] a_s         [3];
  logic [31:0] b_s         [3];
  logic        sg_s        [3];
  logic        out_valid_s [3];
  logic        out_ready_s [3];
  logic        gt_s        [3];
  logic        eq_s        [3];
  logic        lt_s        [3];
  logic        busy_s      [3];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  comparator_serial_unsigned #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut_bpc1 (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear_s[0]),
    .in_valid_i(in_valid_s[0]), .in_ready_o(in_ready_s[0]),
    .a_i(a_s[0]), .b_i(b_s[0]), .signed_i(sg_s[0]),
    .out_valid_o(out_valid_s[0]), .out_ready_i(out_ready_s[0]),
    .greater_o(gt_s[0]), .equal_o(eq_s[0]), .lesser_o(lt_s[0]), .busy_o(busy_s[0]));

  comparator_serial_unsigned #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut_bpc4 (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear_s[1]),
    .in_valid_i(in_valid_s[1]), .in_ready_o(in_ready_s[1]),
    .a_i(a_s[1]), .b_i(b_s[1]), .signed_i(sg_s[1]),
    .out_valid_o(out_valid_s[1]), .out_ready_i(out_ready_s[1]),
    .greater_o(gt_s[1]), .equal_o(eq_s[1]), .lesser_o(lt_s[1]), .busy_o(busy_s[1]));

  comparator_serial_unsigned #(.WIDTH(32), .BITS_PER_CYCLE(32)) dut_bpc32 (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear_s[2]),
    .in_valid_i(in_valid_s[2]), .in_ready_o(in_ready_s[2]),
    .a_i(a_s[2]), .b_i(b_s[2]), .signed_i(sg_s[2]),
    .out_valid_o(out_valid_s[2]), .out_ready_i(out_ready_s[2]),
    .greater_o(gt_s[2]), .equal_o(eq_s[2]), .lesser_o(lt_s[2]), .busy_o(busy_s[2]));

  // Cycles from accept to result for instance k.
  function automatic int n_of(input int k);
    case (k)
      0:       return 32;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  // Reference compare: {greater, equal, lesser}.
  function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    if (sa > sb)       return 3'b100;
    else if (sa == sb) return 3'b010;
    else               return 3'b001;
  endfunction

  // Transaction-level model: phase 0 idle, 1 computing, 2 result held.
  logic [1:0] m_phase [3] = '{2'd0, 2'd0, 2'd0};
  int         m_left  [3] = '{0, 0, 0};
  logic [2:0] m_res   [3] = '{3'b000, 3'b000, 3'b000};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n || clear_s[k]) begin
        m_phase[k] <= 2'd0;
        m_left[k]  <= 0;
      end else begin
        case (m_phase[k])
          2'd0: if (in_valid_s[k]) begin
            m_phase[k] <= 2'd1;
            m_left[k]  <= n_of(k);
            m_res[k]   <= ref_cmp(a_s[k], b_s[k], sg_s[k]);
          end
          2'd1: begin
            m_left[k] <= m_left[k] - 1;
            if (m_left[k] <= 1) m_phase[k] <= 2'd2;
          end
          default: if (out_ready_s[k]) m_phase[k] <= 2'd0;
        endcase
      end
    end
  end

  // Per-cycle compare of every output of every instance against the model.
  always @(negedge clk) begin
    logic [5:0] exp_v, act_v;
    for (int k = 0; k < 3; k++) begin
      exp_v = {m_phase[k] == 2'd0, m_phase[k] == 2'd2, m_phase[k] != 2'd0,
               (m_phase[k] == 2'd2) ? m_res[k] : 3'b000};
      act_v = {in_ready_s[k], out_valid_s[k], busy_s[k], gt_s[k], eq_s[k], lt_s[k]};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL cycle_model inst=%0d t=%0t rdy/vld/busy/gt/eq/lt got=%b want=%b",
                 k, $time, act_v, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  // One full transaction on instance k; exp_code 0 means model-only result check.
  task automatic run_txn(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [2:0] exp_code, input int hold);
    int wait_n;
    int lat;
    logic [2:0] held;
    wait_n = 0;
    while (!in_ready_s[k]) begin
      @(posedge clk); #1;
      wait_n++;
      if (wait_n > 100) begin
        check("ready_timeout", 32'(in_ready_s[k]), 32'd1);
        return;
      end
    end
    in_valid_s[k] = 1'b1; a_s[k] = a; b_s[k] = b; sg_s[k] = s;
    @(posedge clk); #1;
    // Scramble inputs: the captured copies must be unaffected.
    in_valid_s[k] = 1'b0; a_s[k] = $urandom; b_s[k] = $urandom; sg_s[k] = 1'($urandom);
    lat = 0;
    while (!out_valid_s[k] && lat <= 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency_inst%0d", k), 32'(lat), 32'(n_of(k)));
    if (exp_code != 3'b000)
      check($sformatf("result_inst%0d", k), 32'({gt_s[k], eq_s[k], lt_s[k]}), 32'(exp_code));
    held = {gt_s[k], eq_s[k], lt_s[k]};
    // Backpressure with a competing request that must not be accepted.
    in_valid_s[k] = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    if (hold > 0) begin
      check($sformatf("hold_result_inst%0d", k), 32'({gt_s[k], eq_s[k], lt_s[k]}), 32'(held));
      check($sformatf("hold_not_ready_inst%0d", k), 32'(in_ready_s[k]), 32'd0);
    end
    out_ready_s[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[k] = 1'b0;
    in_valid_s[k]  = 1'b0;
  endtask

  task automatic random_run(input int k, input int count);
    logic [31:0] a, b;
    for (int i = 0; i < count; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = $urandom;
      endcase
      run_txn(k, a, b, 1'($urandom), 3'b000, $urandom_range(0, 2));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen_valid;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clear_s[k] = 1'b0; in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b0;
      a_s[k] = '0; b_s[k] = '0; sg_s[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(in_ready_s[0]), 32'd1);
    check("reset_valid_busy", 32'({out_valid_s[0], busy_s[0]}), 32'd0);
    check("reset_flags", 32'({gt_s[0], eq_s[0], lt_s[0]}), 32'd0);
    rst_n = 1'b1;

    // Directed cases with literal expectations.
    run_txn(0, 32'h12345678, 32'h12345678, 1'b0, 3'b010, 0);
    run_txn(0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b100, 0);
    run_txn(0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b001, 0);
    run_txn(0, 32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b001, 0);
    run_txn(0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b100, 0);
    run_txn(0, 32'h00000002, 32'h00000003, 1'b0, 3'b001, 5);
    run_txn(1, 32'h0000000F, 32'h00000010, 1'b0, 3'b001, 0);
    run_txn(1, 32'h80000000, 32'h00000000, 1'b1, 3'b001, 2);
    run_txn(2, 32'h00000005, 32'hFFFFFFFB, 1'b1, 3'b100, 0);
    run_txn(2, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 3'b010, 1);

    // Abort in the middle of RUN, with a request present in the clear cycle.
    in_valid_s[0] = 1'b1; a_s[0] = 32'h1; b_s[0] = 32'h2;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    clear_s[0] = 1'b1; in_valid_s[0] = 1'b1;
    @(posedge clk); #1;
    clear_s[0] = 1'b0; in_valid_s[0] = 1'b0;
    check("clear_to_idle", 32'({in_ready_s[0], busy_s[0]}), 32'b10);
    seen_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid_s[0]) seen_valid = 1'b1;
    end
    check("clear_no_result", 32'(seen_valid), 32'd0);

    // Asynchronous reset in the middle of RUN.
    in_valid_s[0] = 1'b1; a_s[0] = 32'h7; b_s[0] = 32'h7;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_ready", 32'(in_ready_s[0]), 32'd1);
    check("async_rst_outs", 32'({out_valid_s[0], busy_s[0], gt_s[0], eq_s[0], lt_s[0]}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn(0, 32'h00000009, 32'h00000008, 1'b0, 3'b100, 0);

    // Random vectors on all three widths concurrently.
    fork
      random_run(0, 1000);
      random_run(1, 1000);
      random_run(2, 1000);
    join

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
